// File: rtl/perf_reporter.sv
// perf_reporter: queues branch/IPC window results in a small FIFO and serialises each as tag, value[15:8], value[7:0].
// Optional feature: define PERF_RPT_SEQ_EN to carry a 4-bit sequence number in the low nibble of each tag.
module perf_reporter #(
    parameter int BR_W       = 10,
    parameter int IPC_W      = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_br_upd,
    input  logic [BR_W-1:0]  i_br_val,
    input  logic             i_ipc_upd,
    input  logic [IPC_W-1:0] i_ipc_val,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_vld,
    input  logic             i_tx_rdy,
    output logic [7:0]       o_drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
`ifdef PERF_RPT_SEQ_EN
        logic [3:0]  seq;
`endif
        logic        ipc;
        logic [15:0] val;
    } rec_t;

    typedef enum logic [1:0] {IDLE, TAG, HI, LO} state_t;

    state_t        r_state, w_state_nxt;
    rec_t          r_mem [FIFO_DEPTH];
    rec_t          r_hold;
    rec_t          w_br_rec, w_ipc_rec;
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt, w_free;
    logic [7:0]    r_drop, w_tag;
    logic [8:0]    w_drop_sum;
    logic [1:0]    w_n_drop;
    logic          w_hs, w_pop, w_empty, w_wr_br, w_wr_ipc;

    assign o_tx_vld   = r_state != IDLE;
    assign o_drop_cnt = r_drop;
    assign w_hs       = o_tx_vld & i_tx_rdy;
    assign w_empty    = r_cnt == '0;
    assign w_pop      = !w_empty && (r_state == IDLE || (r_state == LO && w_hs));
    // A same-cycle pop frees an entry, so a full FIFO can still accept one push.
    assign w_free     = (AW+1)'(FIFO_DEPTH) - r_cnt + (AW+1)'(w_pop);
    assign w_wr_br    = i_br_upd && w_free != '0;
    assign w_wr_ipc   = i_ipc_upd && (w_free > (AW+1)'(w_wr_br));
    assign w_n_drop   = 2'(i_br_upd & ~w_wr_br) + 2'(i_ipc_upd & ~w_wr_ipc);
    assign w_drop_sum = 9'(r_drop) + 9'(w_n_drop);

`ifdef PERF_RPT_SEQ_EN
    logic [3:0] r_seq;
    assign w_br_rec  = '{seq: r_seq, ipc: 1'b0, val: 16'(i_br_val)};
    assign w_ipc_rec = '{seq: r_seq + 4'(i_br_upd), ipc: 1'b1, val: 16'(i_ipc_val)};
    assign w_tag     = {r_hold.ipc ? 4'hC : 4'hB, r_hold.seq};

    // Sequence number advances once per offered record, dropped ones included.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_seq <= '0;
        else          r_seq <= r_seq + 4'(i_br_upd) + 4'(i_ipc_upd);
    end
`else
    assign w_br_rec  = '{ipc: 1'b0, val: 16'(i_br_val)};
    assign w_ipc_rec = '{ipc: 1'b1, val: 16'(i_ipc_val)};
    assign w_tag     = {r_hold.ipc ? 4'hC : 4'hB, 4'h0};
`endif

    assign o_tx_data = r_state == TAG ? w_tag :
                       r_state == HI  ? r_hold.val[15:8] :
                       r_state == LO  ? r_hold.val[7:0] : 8'h00;

    // Record storage; BR lands ahead of IPC when both are written together.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_wr_br)  r_mem[r_wp] <= w_br_rec;
        if (i_rst_n && w_wr_ipc) r_mem[r_wp + AW'(w_wr_br)] <= w_ipc_rec;
    end

    // FIFO pointers, occupancy, holding register, drop counter and FSM state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            r_drop  <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wp    <= r_wp + AW'(w_wr_br) + AW'(w_wr_ipc);
            r_rp    <= r_rp + AW'(w_pop);
            r_cnt   <= r_cnt + (AW+1)'(w_wr_br) + (AW+1)'(w_wr_ipc) - (AW+1)'(w_pop);
            r_drop  <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
            if (w_pop) r_hold <= r_mem[r_rp];
        end
    end

    // Byte sequencer: each handshake advances one byte; LO chains straight into the next record.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_empty ? IDLE : TAG;
            TAG:     w_state_nxt = w_hs ? HI : TAG;
            HI:      w_state_nxt = w_hs ? LO : HI;
            default: w_state_nxt = !w_hs ? LO : w_empty ? IDLE : TAG;
        endcase
    end
endmodule

// File: tb/tb_perf_reporter.sv
// tb_perf_reporter: directed checks of perf_reporter byte stream, back-pressure, overflow and reset (PERF_RPT_SEQ_EN aware).
module tb_perf_reporter;
    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_br_upd = 1'b0;
    logic [9:0] i_br_val = '0;
    logic       i_ipc_upd = 1'b0;
    logic [9:0] i_ipc_val = '0;
    logic       i_tx_rdy = 1'b0;
    logic [7:0] o_tx_data, o_drop_cnt;
    logic       o_tx_vld;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] seq = '0;
    logic [3:0] s0;

`ifdef PERF_RPT_SEQ_EN
    localparam logic [3:0] SEQ_MASK = 4'hF;
`else
    localparam logic [3:0] SEQ_MASK = 4'h0;
`endif

    perf_reporter dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_br_upd(i_br_upd), .i_br_val(i_br_val),
        .i_ipc_upd(i_ipc_upd), .i_ipc_val(i_ipc_val),
        .o_tx_data(o_tx_data), .o_tx_vld(o_tx_vld), .i_tx_rdy(i_tx_rdy),
        .o_drop_cnt(o_drop_cnt)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] tg(input logic ipc, input logic [3:0] s);
        return {ipc ? 4'hC : 4'hB, s & SEQ_MASK};
    endfunction

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h want %02h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic strobe(input logic br, input logic [9:0] bv, input logic ipc, input logic [9:0] iv);
        i_br_upd = br; i_br_val = bv; i_ipc_upd = ipc; i_ipc_val = iv;
        tick();
        i_br_upd = 1'b0; i_ipc_upd = 1'b0;
        seq = seq + 4'(br) + 4'(ipc);
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] b);
        chk({tag, "_vld"}, 8'(o_tx_vld), 8'h01);
        chk(tag, o_tx_data, b);
        tick();
    endtask

    initial begin
        logic [7:0] exp6 [6];
        // Reset state
        tick(); tick();
        i_rst_n = 1'b1;
        seq = '0;
        chk("rst_vld", 8'(o_tx_vld), 8'h00);
        chk("rst_data", o_tx_data, 8'h00);
        chk("rst_drop", o_drop_cnt, 8'h00);

        // Single BR record, latency N+2
        i_tx_rdy = 1'b1;
        s0 = seq;
        strobe(1'b1, 10'd937, 1'b0, 10'd0);
        chk("lat_n1_vld", 8'(o_tx_vld), 8'h00);
        tick();
        expect_byte("br_tag", tg(1'b0, s0));
        expect_byte("br_hi", 8'h03);
        expect_byte("br_lo", 8'hA9);
        chk("br_idle_vld", 8'(o_tx_vld), 8'h00);
        chk("br_idle_data", o_tx_data, 8'h00);

        // Simultaneous BR + IPC, back to back
        s0 = seq;
        strobe(1'b1, 10'd512, 1'b1, 10'd1000);
        tick();
        exp6 = '{tg(1'b0, s0), 8'h02, 8'h00, tg(1'b1, s0 + 4'd1), 8'h03, 8'hE8};
        for (int i = 0; i < 6; i++) expect_byte($sformatf("dual_b%0d", i), exp6[i]);
        chk("dual_end_vld", 8'(o_tx_vld), 8'h00);

        // Back-pressure hold on the tag byte
        i_tx_rdy = 1'b0;
        s0 = seq;
        strobe(1'b1, 10'h155, 1'b0, 10'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold_vld%0d", i), 8'(o_tx_vld), 8'h01);
            chk($sformatf("hold_data%0d", i), o_tx_data, tg(1'b0, s0));
            tick();
        end
        i_tx_rdy = 1'b1;
        expect_byte("hold_tag", tg(1'b0, s0));
        expect_byte("hold_hi", 8'h01);
        expect_byte("hold_lo", 8'h55);
        chk("hold_end_vld", 8'(o_tx_vld), 8'h00);

        // Overflow: six BR strobes with the port stalled
        i_tx_rdy = 1'b0;
        s0 = seq;
        i_br_upd = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            i_br_val = 10'(i);
            tick();
        end
        i_br_upd = 1'b0;
        seq = seq + 4'd6;
        chk("ovf_drop", o_drop_cnt, 8'h01);
        i_tx_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expect_byte($sformatf("ovf_tag%0d", i), tg(1'b0, s0 + 4'(i)));
            expect_byte($sformatf("ovf_hi%0d", i), 8'h00);
            expect_byte($sformatf("ovf_lo%0d", i), 8'(i + 1));
        end
        chk("ovf_end_vld", 8'(o_tx_vld), 8'h00);
        chk("ovf_drop_kept", o_drop_cnt, 8'h01);

        // Reset while in HI, with a strobe offered during reset
        strobe(1'b1, 10'h234, 1'b0, 10'd0);
        tick();
        tick();
        chk("mid_hi", o_tx_data, 8'h02);
        i_rst_n = 1'b0;
        i_br_upd = 1'b1;
        i_br_val = 10'h3FF;
        tick();
        chk("mrst_vld", 8'(o_tx_vld), 8'h00);
        chk("mrst_data", o_tx_data, 8'h00);
        chk("mrst_drop", o_drop_cnt, 8'h00);
        i_rst_n = 1'b1;
        i_br_upd = 1'b0;
        seq = '0;
        tick();
        chk("mrst_empty1", 8'(o_tx_vld), 8'h00);
        tick();
        chk("mrst_empty2", 8'(o_tx_vld), 8'h00);
        s0 = seq;
        strobe(1'b1, 10'h042, 1'b0, 10'd0);
        tick();
        expect_byte("fresh_tag", tg(1'b0, s0));
        expect_byte("fresh_hi", 8'h00);
        expect_byte("fresh_lo", 8'h42);

        // 17 spaced BR records: tags walk the sequence and wrap
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        seq = '0;
        for (int i = 0; i < 17; i++) begin
            s0 = seq;
            strobe(1'b1, 10'(i), 1'b0, 10'd0);
            tick();
            chk($sformatf("seq_tag%0d", i), o_tx_data, tg(1'b0, s0));
            tick(); tick(); tick();
        end
        chk("seq_end_vld", 8'(o_tx_vld), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
